game_flow_controller: RTL and testbench
=======================================

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 The block SHALL have a parameter BOOST_STEP, default 10, giving the number of score points per lava speed boost.
REQ-002 The block SHALL have a parameter MAX_BOOSTS, default 7, giving the maximum speed boosts issued per round.
REQ-003 The block SHALL have a parameter HOLD_TICKS, default 120, giving the minimum number of game_ticks spent in WIN or GAME_OVER before a restart is accepted.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 game_tick  input  1  one-clk frame strobe; all state updates occur only on cycles with game_tick=1.
REQ-007 start_btn  input  1  start/restart button level.
REQ-008 coin_pulse  input  1  collectible event, sampled on game_tick.
REQ-009 hit_lava_wall  input  1  lava collision flag from the lava stage, sampled on game_tick.
REQ-010 reached_goal  input  1  player at goal, sampled on game_tick.
REQ-011 state  output  2  IDLE=00, PLAY=01, WIN=10, GAME_OVER=11.
REQ-012 freeze  output  1  high iff state is WIN or GAME_OVER.
REQ-013 score  output  16  current round score.
REQ-014 speed_boost_pulse  output  1  boost request to the lava stage.
REQ-015 restart_pulse  output  1  one-clk round-restart strobe to the downstream stages.
REQ-016 high_score  output  16  best score (see Configuration).

Function
REQ-017 IDLE->PLAY SHALL occur on a tick where start_btn=1 and start_btn was 0 at the previous tick (rising edge across ticks).
REQ-018 PLAY->GAME_OVER SHALL occur on a tick with hit_lava_wall=1.
REQ-019 PLAY->WIN SHALL occur on a tick with reached_goal=1 and hit_lava_wall=0; when both are 1 on the same tick, GAME_OVER SHALL win.
REQ-020 On entry to WIN or GAME_OVER, hold_cnt SHALL clear; it SHALL increment on each tick and saturate at HOLD_TICKS.
REQ-021 WIN/GAME_OVER->IDLE SHALL occur on a tick where hold_cnt==HOLD_TICKS and start_btn shows a rising edge across ticks.
REQ-022 On that exit transition, the block SHALL clear score, the boost count and any pending boost, and SHALL assert restart_pulse for exactly one clk.
REQ-023 In PLAY, coin_pulse=1 on a tick SHALL add 1 to score, saturating at 16'hFFFF; coins SHALL be ignored in every other state, including the tick of the PLAY exit.
REQ-024 When a score increment makes score a nonzero multiple of BOOST_STEP and fewer than MAX_BOOSTS boosts have been issued this round, a boost SHALL become pending.
REQ-025 speed_boost_pulse SHALL rise one clk after the pending tick, stay high through the next game_tick cycle inclusive, and clear at that tick's clock edge, so a tick-sampling consumer sees exactly one boost.
REQ-026 The boost count SHALL increment when speed_boost_pulse is consumed; no boost SHALL be issued once the state has left PLAY, and a pending boost SHALL be dropped on leaving PLAY.
REQ-027 Outputs state, freeze, score, speed_boost_pulse and restart_pulse SHALL be registered or derived only from registered state.

Reset
REQ-028 On rst=0, the block SHALL asynchronously set state=IDLE, freeze=0, score=0, speed_boost_pulse=0, restart_pulse=0, high_score=0, hold_cnt=0, boost count=0 and the previous start_btn sample=1.
REQ-029 Reset asserted mid-round SHALL abort the round with no restart_pulse generated.

Configuration
REQ-030 With macro HIGH_SCORE_EN defined, on entry to WIN or GAME_OVER high_score SHALL load score if score>high_score, and SHALL be retained across restarts until rst.
REQ-031 Without HIGH_SCORE_EN, high_score SHALL be constant 0 and no high-score register SHALL be synthesized.

Verification
REQ-032 Reset, then start_btn 0->1 across two ticks -> state=01, freeze=0.
REQ-033 PLAY, 10 coin ticks -> score=10, speed_boost_pulse high through exactly one game_tick; 80 coins total -> exactly 7 boosts issued.
REQ-034 PLAY, hit_lava_wall=1 and reached_goal=1 on the same tick -> state=11, freeze=1.
REQ-035 GAME_OVER, start_btn rising edge after 50 ticks -> no exit; rising edge after 120 ticks -> state=00, score=0, restart_pulse high for 1 clk.
REQ-036 HIGH_SCORE_EN defined, rounds scoring 25 then 12 -> high_score=25 after the second round.
REQ-037 rst pulsed low in PLAY with score=5 -> all outputs at their reset values immediately, no restart_pulse.

Source files
------------

// File: rtl/game_flow_controller.sv
// game_flow_controller: round sequencer for the lava game.
// Runs IDLE -> PLAY -> WIN/GAME_OVER -> IDLE. Counts coins into a saturating score,
// requests lava speed boosts every BOOST_STEP points (at most MAX_BOOSTS per round),
// and holds the end screen for HOLD_TICKS frames before a restart is accepted.
// Optional feature: define HIGH_SCORE_EN to keep a best-score register across rounds;
// without it high_score is tied to zero.
module game_flow_controller #(
  parameter int BOOST_STEP = 10,
  parameter int MAX_BOOSTS = 7,
  parameter int HOLD_TICKS = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic        start_btn,
  input  logic        coin_pulse,
  input  logic        hit_lava_wall,
  input  logic        reached_goal,
  output logic [1:0]  state,
  output logic        freeze,
  output logic [15:0] score,
  output logic        speed_boost_pulse,
  output logic        restart_pulse,
  output logic [15:0] high_score
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    WIN       = 2'b10,
    GAME_OVER = 2'b11
  } state_t;

  localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int BW = (MAX_BOOSTS < 1) ? 1 : $clog2(MAX_BOOSTS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  state_t         state_q;
  logic           prev_start;
  logic           boost_pending;
  logic [HW-1:0]  hold_cnt;
  logic [BW-1:0]  boost_cnt;
  logic           start_rise;
  logic           end_round;
  logic           coin_take;
  logic           boost_hit;
  logic [15:0]    score_inc;

  // Button edge is measured between consecutive ticks, not consecutive clocks.
  assign start_rise = start_btn & ~prev_start;

  // A collision or goal on a PLAY tick ends the round; that tick's coin is discarded.
  assign end_round = game_tick & (state_q == PLAY) & (hit_lava_wall | reached_goal);
  assign coin_take = game_tick & (state_q == PLAY) & ~hit_lava_wall & ~reached_goal
                     & coin_pulse & (score != 16'hFFFF);
  assign score_inc = score + 16'd1;

  // Boosts already in flight (pending or on the wire) count against the round limit.
  assign boost_hit = coin_take && ((32'(score_inc) % BOOST_STEP) == 0) &&
                     ((int'(boost_cnt) + int'(boost_pending) + int'(speed_boost_pulse)) < MAX_BOOSTS);

  assign state  = state_q;
  assign freeze = state_q[1];

  // Round state machine, score, hold timer and the boost handshake toward the lava stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      prev_start        <= 1'b1;
      score             <= 16'd0;
      hold_cnt          <= '0;
      boost_cnt         <= '0;
      boost_pending     <= 1'b0;
      speed_boost_pulse <= 1'b0;
      restart_pulse     <= 1'b0;
    end else begin
      restart_pulse <= 1'b0;
      boost_pending <= boost_hit;
      if (speed_boost_pulse && game_tick) begin
        speed_boost_pulse <= 1'b0;
        boost_cnt         <= boost_cnt + 1'b1;
      end else if (boost_pending && !end_round && state_q == PLAY) begin
        speed_boost_pulse <= 1'b1;
      end
      if (game_tick) begin
        prev_start <= start_btn;
        case (state_q)
          IDLE: begin
            if (start_rise) state_q <= PLAY;
          end
          PLAY: begin
            if (hit_lava_wall) begin
              state_q  <= GAME_OVER;
              hold_cnt <= '0;
            end else if (reached_goal) begin
              state_q  <= WIN;
              hold_cnt <= '0;
            end else if (coin_take) begin
              score <= score_inc;
            end
          end
          WIN, GAME_OVER: begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_MAX && start_rise) begin
              state_q       <= IDLE;
              score         <= 16'd0;
              boost_cnt     <= '0;
              hold_cnt      <= '0;
              restart_pulse <= 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef HIGH_SCORE_EN
  logic [15:0] best_q;

  // Capture the round score as the new best when the round ends with a higher score.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q <= 16'd0;
    end else if (end_round && score > best_q) begin
      best_q <= score;
    end
  end

  assign high_score = best_q;
`else
  assign high_score = 16'd0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: scoreboard bench for game_flow_controller.
// Each tick pushes the model's expected outputs and the observed outputs into queues;
// every scenario task drains and compares them itself.
module tb_game_flow_controller;

  localparam int BOOST_STEP = 10;
  localparam int MAX_BOOSTS = 7;
  localparam int HOLD_TICKS = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        coin_pulse = 1'b0;
  logic        hit_lava_wall = 1'b0;
  logic        reached_goal = 1'b0;
  logic [1:0]  state;
  logic        freeze;
  logic [15:0] score;
  logic        speed_boost_pulse;
  logic        restart_pulse;
  logic [15:0] high_score;

  game_flow_controller #(
    .BOOST_STEP(BOOST_STEP),
    .MAX_BOOSTS(MAX_BOOSTS),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_tick(game_tick),
    .start_btn(start_btn),
    .coin_pulse(coin_pulse),
    .hit_lava_wall(hit_lava_wall),
    .reached_goal(reached_goal),
    .state(state),
    .freeze(freeze),
    .score(score),
    .speed_boost_pulse(speed_boost_pulse),
    .restart_pulse(restart_pulse),
    .high_score(high_score)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pulse_seen = 0;

  logic [35:0] exp_q[$];
  logic [35:0] act_q[$];

  logic [1:0]  m_state;
  logic [15:0] m_score;
  logic [15:0] m_high;
  logic        m_prev;
  logic        m_restart;
  int          m_hold;
  int          m_boosts;

  task automatic model_reset();
    m_state = 2'b00; m_score = 16'd0; m_high = 16'd0; m_prev = 1'b1;
    m_restart = 1'b0; m_hold = 0; m_boosts = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One frame: drive inputs with game_tick high for one clk, then one idle clk.
  task automatic tick(input logic s, input logic c, input logic h, input logic g);
    logic rise;
    @(negedge clk);
    start_btn = s; coin_pulse = c; hit_lava_wall = h; reached_goal = g; game_tick = 1'b1;
    pulse_seen += int'(speed_boost_pulse);
    rise = s && !m_prev;
    m_prev = s;
    m_restart = 1'b0;
    case (m_state)
      2'b00: if (rise) m_state = 2'b01;
      2'b01: begin
        if (h || g) begin
`ifdef HIGH_SCORE_EN
          if (m_score > m_high) m_high = m_score;
`endif
          m_state = h ? 2'b11 : 2'b10;
          m_hold = 0;
        end else if (c && m_score != 16'hFFFF) begin
          m_score = m_score + 16'd1;
          if ((int'(m_score) % BOOST_STEP) == 0 && m_boosts < MAX_BOOSTS) m_boosts++;
        end
      end
      default: begin
        if (m_hold == HOLD_TICKS && rise) begin
          m_state = 2'b00; m_score = 16'd0; m_restart = 1'b1; m_boosts = 0;
        end else if (m_hold < HOLD_TICKS) begin
          m_hold++;
        end
      end
    endcase
    exp_q.push_back({m_state, m_state[1], m_score, m_restart, m_high});
    @(posedge clk);
    #1 act_q.push_back({state, freeze, score, restart_pulse, high_score});
    @(negedge clk);
    game_tick = 1'b0; coin_pulse = 1'b0; hit_lava_wall = 1'b0; reached_goal = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (state !== 2'b00) $display("[TB] FAIL reset_state got %b want 00", state); else passes++;
    checks++; if (freeze !== 1'b0) $display("[TB] FAIL reset_freeze got %b want 0", freeze); else passes++;
    checks++; if (score !== 16'd0) $display("[TB] FAIL reset_score got %h want 0000", score); else passes++;
    checks++; if (speed_boost_pulse !== 1'b0) $display("[TB] FAIL reset_boost got %b want 0", speed_boost_pulse); else passes++;
    checks++; if (restart_pulse !== 1'b0) $display("[TB] FAIL reset_restart got %b want 0", restart_pulse); else passes++;
    checks++; if (high_score !== 16'd0) $display("[TB] FAIL reset_high got %h want 0000", high_score); else passes++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [35:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) $display("[TB] FAIL start got %h want %h", a, e); else passes++;
    end
  endtask

  task automatic test_boost();
    pulse_seen = 0;
    repeat (10) tick(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++; if (speed_boost_pulse !== 1'b1) $display("[TB] FAIL boost_rise got %b want 1", speed_boost_pulse); else passes++;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pulse_seen !== 1) $display("[TB] FAIL boost_first_count got %0d want 1", pulse_seen); else passes++;
    checks++; if (speed_boost_pulse !== 1'b0) $display("[TB] FAIL boost_clear got %b want 0", speed_boost_pulse); else passes++;
    repeat (70) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pulse_seen !== m_boosts) $display("[TB] FAIL boost_total got %0d want %0d", pulse_seen, m_boosts); else passes++;
    checks++; if (pulse_seen !== MAX_BOOSTS) $display("[TB] FAIL boost_limit got %0d want %0d", pulse_seen, MAX_BOOSTS); else passes++;
    while (exp_q.size() > 0) begin
      logic [35:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) $display("[TB] FAIL boost_tick got %h want %h", a, e); else passes++;
    end
  endtask

  task automatic test_collision();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      logic [35:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) $display("[TB] FAIL collision got %h want %h", a, e); else passes++;
    end
    checks++; if (state !== 2'b11) $display("[TB] FAIL collision_state got %b want 11", state); else passes++;
  endtask

  task automatic test_hold();
    repeat (50) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 2'b11) $display("[TB] FAIL early_exit got %b want 11", state); else passes++;
    while (m_hold < HOLD_TICKS) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [35:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) $display("[TB] FAIL hold got %h want %h", a, e); else passes++;
    end
    @(posedge clk);
    #1;
    checks++; if (restart_pulse !== 1'b0) $display("[TB] FAIL restart_width got %b want 0", restart_pulse); else passes++;
  endtask

  task automatic test_high_score();
    logic [15:0] want;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (25) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    while (m_hold < HOLD_TICKS) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      logic [35:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) $display("[TB] FAIL high_round got %h want %h", a, e); else passes++;
    end
`ifdef HIGH_SCORE_EN
    want = 16'd25;
`else
    want = 16'd0;
`endif
    checks++; if (high_score !== want) $display("[TB] FAIL high_score got %0d want %0d", high_score, want); else passes++;
  endtask

  task automatic test_reset_mid();
    int restarts;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      logic [35:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) $display("[TB] FAIL mid_round got %h want %h", a, e); else passes++;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (state !== 2'b00) $display("[TB] FAIL mid_reset_state got %b want 00", state); else passes++;
    checks++; if (score !== 16'd0) $display("[TB] FAIL mid_reset_score got %h want 0000", score); else passes++;
    checks++; if (freeze !== 1'b0) $display("[TB] FAIL mid_reset_freeze got %b want 0", freeze); else passes++;
    checks++; if (speed_boost_pulse !== 1'b0) $display("[TB] FAIL mid_reset_boost got %b want 0", speed_boost_pulse); else passes++;
    restarts = 0;
    repeat (2) begin
      @(posedge clk); #1 restarts += int'(restart_pulse);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1 restarts += int'(restart_pulse);
    end
    checks++; if (restarts !== 0) $display("[TB] FAIL mid_reset_restart got %0d want 0", restarts); else passes++;
  endtask

  // Scenario sequence.
  initial begin
    model_reset();
    $display("[TB] starting game_flow_controller bench");
    test_reset();
    test_start();
    test_boost();
    test_collision();
    test_hold();
    test_high_score();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
